// File: rtl/circuit_sweep_checker.sv
// Exhaustive 32-vector sweep of a 5-in/2-out circuit under test: drive each vector,
// wait for the response to settle and hold stable, then grade it against a truth table.
module circuit_sweep_checker #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [63:0] expected_lut,
  output logic [4:0]  stim,
  input  logic [1:0]  resp,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [5:0]  fail_count,
  output logic [4:0]  first_fail_vec,
  output logic        first_fail_unstable,
  output logic        err_pulse
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state, state_nxt;

  logic [4:0]    v;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] samp_cnt, stable_cnt, samp_nxt, cnt_nxt;
  logic [1:0]    sync1, resp_s, ref_q, ref_nxt, exp_v;
  logic          restart, clear, stable_hit, timeout, verdict, vfail;

  assign busy = (state == SETTLE) || (state == SAMPLE);
  assign done = (state == DONE);
  assign pass = done && (fail_count == 6'd0);
  assign stim = v;
  assign exp_v = expected_lut[{v, 1'b0} +: 2];

  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    clear      = 1'b0;
    // The first SAMPLE cycle always (re)loads the reference.
    ref_nxt    = resp_s;
    cnt_nxt    = TW'(1);
    if (samp_cnt != '0 && resp_s == ref_q) begin
      ref_nxt = ref_q;
      cnt_nxt = stable_cnt + TW'(1);
    end
    samp_nxt   = samp_cnt + TW'(1);
    stable_hit = (cnt_nxt == TW'(STABLE_CYCLES));
    timeout    = !stable_hit && (samp_nxt == TW'(TIMEOUT_CYCLES));
    verdict    = (state == SAMPLE) && (stable_hit || timeout);
    vfail      = verdict && (timeout || ref_nxt != exp_v);
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = SETTLE;
        restart   = 1'b1;
      end
      SETTLE: if (abort) begin
        state_nxt = IDLE;
        clear     = 1'b1;
      end else if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
        state_nxt = SAMPLE;
      end
      SAMPLE: if (abort) begin
        state_nxt = IDLE;
        clear     = 1'b1;
      end else if (verdict) begin
        state_nxt = (v == 5'd31) ? DONE : SETTLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      v                   <= '0;
      settle_cnt          <= '0;
      samp_cnt            <= '0;
      stable_cnt          <= '0;
      sync1               <= '0;
      resp_s              <= '0;
      ref_q               <= '0;
      fail_count          <= '0;
      first_fail_vec      <= '0;
      first_fail_unstable <= 1'b0;
      err_pulse           <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync1     <= resp;
      resp_s    <= sync1;
      err_pulse <= 1'b0;
      if (restart || clear) begin
        v                   <= '0;
        settle_cnt          <= '0;
        samp_cnt            <= '0;
        stable_cnt          <= '0;
        fail_count          <= '0;
        first_fail_vec      <= '0;
        first_fail_unstable <= 1'b0;
      end else if (state == SETTLE) begin
        settle_cnt <= (state_nxt == SAMPLE) ? '0 : settle_cnt + SW'(1);
        samp_cnt   <= '0;
      end else if (state == SAMPLE) begin
        samp_cnt   <= samp_nxt;
        stable_cnt <= cnt_nxt;
        ref_q      <= ref_nxt;
        if (verdict) begin
          samp_cnt <= '0;
          if (v != 5'd31) v <= v + 5'd1;
          if (vfail) begin
            fail_count <= fail_count + 6'd1;
            err_pulse  <= 1'b1;
            if (fail_count == 6'd0) begin
              first_fail_vec      <= v;
              first_fail_unstable <= timeout;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_circuit_sweep_checker.sv
// Directed bench: a behavioural circuit model answers the sweep; each task checks one scenario.
module tb_circuit_sweep_checker;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [63:0] lut;
  logic [4:0]  stim, first_fail_vec, prev_stim;
  logic [1:0]  resp = 2'b00;
  logic        busy, done, pass, first_fail_unstable, err_pulse, tog = 1'b0;
  logic [5:0]  fail_count;
  int total = 0, bad = 0, err_seen = 0, vcnt = 0, mode = 0;

  circuit_sweep_checker #(.SETTLE_CYCLES(4), .STABLE_CYCLES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected_lut(lut),
    .stim(stim), .resp(resp), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_vec(first_fail_vec),
    .first_fail_unstable(first_fail_unstable), .err_pulse(err_pulse));

  always #5 clk = ~clk;

  // Circuit model: 0 ideal, 1 out2 stuck low on vector 10, 2 toggling on vector 3,
  // 3 vector 6 glitches and only settles by the second sample cycle.
  always @(negedge clk) begin
    logic [1:0] r;
    if (stim != prev_stim) vcnt = 0; else vcnt = vcnt + 1;
    prev_stim = stim;
    tog = ~tog;
    r = lut[2*stim +: 2];
    case (mode)
      1: if (stim == 5'd10) r[1] = 1'b0;
      2: if (stim == 5'd3) r = r ^ {1'b0, tog};
      3: if (stim == 5'd6 && (vcnt == 0 || vcnt == 2)) r = ~r;
      default: ;
    endcase
    resp = r;
    if (err_pulse) err_seen = err_seen + 1;
  end

  task automatic start_and_wait(output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 0;
    while (!done && cyc < 2000) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic wait_stim(input logic [4:0] n);
    int k = 0;
    while (stim != n && k < 1000) begin @(posedge clk); #1; k++; end
    total++;
    if (stim != n) begin bad++; $display("FAIL wait_stim: stim=%0d required=%0d", stim, n); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk); #1;
    total++;
    if ({stim, busy, done, pass, fail_count, first_fail_vec, first_fail_unstable, err_pulse} !== '0) begin
      bad++; $display("FAIL reset: stim=%0d busy=%b done=%b pass=%b fc=%0d ffv=%0d unst=%b err=%b required all 0",
        stim, busy, done, pass, fail_count, first_fail_vec, first_fail_unstable, err_pulse);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ideal();
    int cyc, e0;
    mode = 0; e0 = err_seen;
    start_and_wait(cyc);
    total++; if (cyc !== 192) begin bad++; $display("FAIL ideal_latency: got=%0d required=192", cyc); end
    total++; if ({pass, fail_count, busy, stim} !== {1'b1, 6'd0, 1'b0, 5'd31}) begin
      bad++; $display("FAIL ideal_result: pass=%b fc=%0d busy=%b stim=%0d required 1/0/0/31", pass, fail_count, busy, stim); end
    total++; if (err_seen - e0 != 0) begin bad++; $display("FAIL ideal_err: pulses=%0d required=0", err_seen - e0); end
  endtask

  task automatic test_mismatch();
    int cyc, e0;
    mode = 1; e0 = err_seen;
    start_and_wait(cyc);
    total++; if (cyc !== 192) begin bad++; $display("FAIL mismatch_latency: got=%0d required=192", cyc); end
    total++; if ({pass, fail_count, first_fail_vec, first_fail_unstable} !== {1'b0, 6'd1, 5'd10, 1'b0}) begin
      bad++; $display("FAIL mismatch_result: pass=%b fc=%0d ffv=%0d unst=%b required 0/1/10/0",
        pass, fail_count, first_fail_vec, first_fail_unstable); end
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL mismatch_err: pulses=%0d required=1", err_seen - e0); end
  endtask

  task automatic test_timeout();
    int cyc, e0;
    mode = 2; e0 = err_seen;
    start_and_wait(cyc);
    total++; if (cyc !== 198) begin bad++; $display("FAIL timeout_latency: got=%0d required=198", cyc); end
    total++; if ({pass, fail_count, first_fail_vec, first_fail_unstable} !== {1'b0, 6'd1, 5'd3, 1'b1}) begin
      bad++; $display("FAIL timeout_result: pass=%b fc=%0d ffv=%0d unst=%b required 0/1/3/1",
        pass, fail_count, first_fail_vec, first_fail_unstable); end
    total++; if (err_seen - e0 != 1) begin bad++; $display("FAIL timeout_err: pulses=%0d required=1", err_seen - e0); end
  endtask

  task automatic test_late_settle();
    int cyc;
    mode = 3;
    start_and_wait(cyc);
    total++; if (cyc !== 193) begin bad++; $display("FAIL late_latency: got=%0d required=193", cyc); end
    total++; if ({pass, fail_count} !== {1'b1, 6'd0}) begin
      bad++; $display("FAIL late_result: pass=%b fc=%0d required 1/0", pass, fail_count); end
  endtask

  task automatic test_abort();
    int cyc;
    mode = 2;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_stim(5'd7);
    total++; if (fail_count !== 6'd1) begin bad++; $display("FAIL abort_pre: fc=%0d required=1", fail_count); end
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(posedge clk); #1; abort = 1'b0; start = 1'b0;
    total++; if ({stim, busy, done, fail_count} !== '0) begin
      bad++; $display("FAIL abort_state: stim=%0d busy=%b done=%b fc=%0d required all 0", stim, busy, done, fail_count); end
    mode = 0;
    start_and_wait(cyc);
    total++; if (cyc !== 192 || pass !== 1'b1) begin
      bad++; $display("FAIL abort_rerun: cyc=%0d pass=%b required 192/1", cyc, pass); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    mode = 2;
    @(negedge clk); start = 1'b1; @(negedge clk); start = 1'b0;
    wait_stim(5'd5);
    repeat (5) @(posedge clk);
    #2;
    total++; if (fail_count !== 6'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: fc=%0d busy=%b required 1/1", fail_count, busy); end
    rst_n = 1'b0; #1;
    total++; if ({stim, busy, done, pass, fail_count, first_fail_vec, first_fail_unstable, err_pulse} !== '0) begin
      bad++; $display("FAIL midrst: stim=%0d busy=%b done=%b fc=%0d ffv=%0d unst=%b required all 0",
        stim, busy, done, fail_count, first_fail_vec, first_fail_unstable); end
    @(negedge clk); rst_n = 1'b1;
    // start pulse while busy must not restart the sweep
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 0;
    repeat (20) begin @(posedge clk); #1; cyc++; end
    start = 1'b1; @(posedge clk); #1; cyc++; start = 1'b0;
    total++; if (stim !== 5'd3) begin bad++; $display("FAIL busy_start_stim: stim=%0d required=3", stim); end
    while (!done && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 192 || pass !== 1'b1) begin
      bad++; $display("FAIL busy_start_latency: cyc=%0d pass=%b required 192/1", cyc, pass); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = 1;
    start_and_wait(cyc);
    @(negedge clk); abort = 1'b1; @(negedge clk); abort = 1'b0;
    total++; if ({done, fail_count, stim} !== {1'b1, 6'd1, 5'd31}) begin
      bad++; $display("FAIL done_abort: done=%b fc=%0d stim=%0d required 1/1/31", done, fail_count, stim); end
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; cyc = 0;
    total++; if ({fail_count, busy, done, stim} !== {6'd0, 1'b1, 1'b0, 5'd0}) begin
      bad++; $display("FAIL restart_clear: fc=%0d busy=%b done=%b stim=%0d required 0/1/0/0", fail_count, busy, done, stim); end
    while (!done && cyc < 2000) begin @(posedge clk); #1; cyc++; end
    total++; if (cyc !== 192 || pass !== 1'b1) begin
      bad++; $display("FAIL restart_sweep: cyc=%0d pass=%b required 192/1", cyc, pass); end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) lut[2*i +: 2] = 2'((3*i + 1) & 3);
    test_reset();
    test_ideal();
    test_mismatch();
    test_timeout();
    test_late_settle();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
